// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts a byte + odd parity + stop on device clock falls, then checks the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send_valid,
  input  logic [7:0] send_data,
  output logic       send_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_REL
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    idx_q, idx_d;
  logic [9:0]    frame_q, frame_d;
  logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic          done_q, done_d, error_q, error_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [2:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic          clk_s, data_s, fall, timeout;

  // bit [1] is the synchronised level, bit [2] its previous value
  assign clk_s   = clk_sync_q[1];
  assign data_s  = data_sync_q[1];
  assign fall    = clk_sync_q[2] & ~clk_sync_q[1];
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  assign timeout = (cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    err_code_d  = err_code_q;
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};
    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (send_valid) begin
          frame_d    = {1'b1, ~^send_data, send_data};
          clk_oe_d   = 1'b1;
          cnt_d      = '0;
          err_code_d = 2'b00;
          state_d    = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = S_RTS;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RTS: begin
        clk_oe_d = 1'b0;
        idx_d    = 4'd0;
        cnt_d    = '0;
        state_d  = S_SHIFT;
      end
      default: begin
        cnt_d = cnt_inc;
        // a timeout wins over any edge seen in the same cycle
        if (timeout) begin
          clk_oe_d   = 1'b0;
          data_oe_d  = 1'b0;
          error_d    = 1'b1;
          err_code_d = 2'b01;
          state_d    = S_IDLE;
        end else if (state_q == S_SHIFT) begin
          if (fall) begin
            data_oe_d = ~frame_q[idx_q];
            if (idx_q == 4'd9) state_d = S_ACK;
            else               idx_d   = idx_q + 4'd1;
          end
        end else if (state_q == S_ACK) begin
          if (fall) begin
            if (!data_s) begin
              state_d = S_WAIT_REL;
            end else begin
              error_d    = 1'b1;
              err_code_d = 2'b10;
              state_d    = S_IDLE;
            end
          end
        end else if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= 4'd0;
      frame_q     <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'b00;
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
    end
  end

  assign send_ready  = (state_q == S_IDLE) & ~reset;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on open-drain lines, with a
// scoreboard of expected outcomes checked by an independent monitor.
module tb_ps2_host_tx;

  localparam int INH = 5000;
  localparam int TO  = 1500;
  localparam int M_ACK = 0, M_NACK = 1, M_TO = 2, M_RST = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       send_valid = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic       send_ready;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       done, error;
  logic [1:0] err_code;
  logic       dev_clk = 1'b1, dev_data = 1'b1;

  // open-drain lines: low if either side pulls
  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .send_valid(send_valid), .send_data(send_data),
    .send_ready(send_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .done(done), .error(error),
    .err_code(err_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit        is_err;
    bit [1:0]  code;
    bit        chk_frame;
    bit [10:0] frame;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          accepts = 0;
  logic [10:0] cap_frame = '0;
  logic [1:0]  last_code = 2'b00;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // line-level frame as the device sees it: start, data LSB first, odd parity, stop
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  always @(posedge clock) if (send_valid && send_ready) accepts++;

  always @(negedge clock) begin
    if (done || error) begin
      chk("done_error_exclusive", int'(done && error), 0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: done=%0d error=%0d, expected no pulse", done, error);
      end else begin
        mon_e = sb.pop_front();
        chk("outcome_is_error", int'(error), int'(mon_e.is_err));
        if (mon_e.is_err) chk("err_code", int'(err_code), int'(mon_e.code));
        if (mon_e.chk_frame) chk("frame", int'(cap_frame), int'(mon_e.frame));
      end
    end
  end

  task automatic run_xfer(input logic [7:0] d, input int mode, input bit hold);
    int          cnt, h;
    logic [10:0] fr;
    exp_t        x;
    h = $urandom_range(5, 20);
    send_data  = d;
    send_valid = 1'b1;
    chk("ready_before_accept", int'(send_ready), 1);
    chk("err_code_held", int'(err_code), int'(last_code));
    x.is_err    = (mode != M_ACK);
    x.code      = (mode == M_NACK) ? 2'b10 : (mode == M_TO) ? 2'b01 : 2'b00;
    x.chk_frame = (mode != M_TO);
    x.frame     = exp_frame(d);
    if (mode != M_RST) sb.push_back(x);
    last_code = (mode == M_RST) ? 2'b00 : x.code;
    @(negedge clock);
    if (!hold) send_valid = 1'b0;
    chk("err_code_cleared_on_accept", int'(err_code), 0);
    cnt = 0;
    while (ps2_clk_oe && !ps2_data_oe && cnt <= INH + 10) begin
      cnt++;
      @(negedge clock);
    end
    chk("inhibit_cycles", cnt, INH);
    chk("rts_both_oe", int'({ps2_clk_oe, ps2_data_oe}), 3);
    @(negedge clock);
    chk("clk_release_start_bit", int'({ps2_clk_oe, ps2_data_oe}), 1);
    if (mode == M_TO) begin
      cnt = 0;
      while (!error && cnt <= TO + 10) begin
        @(negedge clock);
        cnt++;
      end
      chk("timeout_latency", cnt, TO);
      chk("timeout_oes_released", int'({ps2_clk_oe, ps2_data_oe}), 0);
      chk("ready_after_timeout", int'(send_ready), 1);
      return;
    end
    fr = '0;
    fr[0] = ps2_data_in;
    cyc(h);
    for (int i = 0; i < 10; i++) begin
      cyc(h);
      dev_clk = 1'b0;
      cyc(h);
      dev_clk = 1'b1;
      fr[i+1] = ps2_data_in;
      if (mode == M_RST && i == 3) begin
        reset = 1'b1;
        @(negedge clock);
        chk("reset_releases_oes", int'({ps2_clk_oe, ps2_data_oe}), 0);
        chk("ready_low_in_reset", int'(send_ready), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("ready_after_reset", int'(send_ready), 1);
        return;
      end
    end
    cap_frame = fr;
    if (mode == M_ACK) dev_data = 1'b0;
    cyc(h);
    dev_clk = 1'b0;
    cyc(h);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    cnt = 0;
    while (!send_ready && cnt < 100) begin
      @(negedge clock);
      cnt++;
    end
    chk("returned_to_idle", int'(send_ready), 1);
    chk("idle_oes_released", int'({ps2_clk_oe, ps2_data_oe}), 0);
  endtask

  initial begin
    #(950000 * 10);
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    int         acc0, m;
    cyc(3);
    chk("rst_clk_oe", int'(ps2_clk_oe), 0);
    chk("rst_data_oe", int'(ps2_data_oe), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_err_code", int'(err_code), 0);
    chk("rst_send_ready", int'(send_ready), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_deassert", int'(send_ready), 1);

    run_xfer(8'hED, M_ACK, 1'b0);
    chk("frame_ED", int'(cap_frame), int'(11'b11_1110_1101_0));
    cyc(2);
    run_xfer(8'h00, M_ACK, 1'b0);
    chk("parity_00", int'(cap_frame[9]), 1);
    cyc(2);
    run_xfer(8'h01, M_ACK, 1'b0);
    chk("parity_01", int'(cap_frame[9]), 0);
    cyc(2);
    rd = 8'($urandom_range(0, 255));
    run_xfer(rd, M_NACK, 1'b0);
    cyc(2);
    rd = 8'($urandom_range(0, 255));
    run_xfer(rd, M_TO, 1'b0);
    cyc(2);
    rd = 8'($urandom_range(0, 255));
    run_xfer(rd, M_RST, 1'b0);
    cyc(2);
    run_xfer(8'hF4, M_ACK, 1'b0);
    cyc(2);

    acc0 = accepts;
    run_xfer(8'hED, M_ACK, 1'b1);
    chk("one_accept_while_held", accepts - acc0, 1);
    run_xfer(8'h5A, M_ACK, 1'b0);
    chk("second_accept_after_done", accepts - acc0, 2);
    cyc(2);

    for (int k = 0; k < 3; k++) begin
      rd = 8'($urandom_range(0, 255));
      m  = $urandom_range(0, 1);
      run_xfer(rd, m, 1'b0);
      cyc(2);
    end

    cyc(5);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clock-low hold time in clock cycles (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000, maximum transfer duration after clock release (15 ms at 50 MHz).
REQ-003 SHALL have port clock, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port send_valid, input, 1, request to transmit send_data.
REQ-006 SHALL have port send_data, input, 8, byte to send to the device (e.g. 8'hED LED command).
REQ-007 SHALL have port send_ready, output, 1, high only in IDLE; a transfer is accepted when send_valid && send_ready.
REQ-008 SHALL have port ps2_clk_in, input, 1, raw PS/2 clock line level.
REQ-009 SHALL have port ps2_data_in, input, 1, raw PS/2 data line level.
REQ-010 SHALL have port ps2_clk_oe, output, 1, 1 = pull the PS/2 clock line low; 0 = release it.
REQ-011 SHALL have port ps2_data_oe, output, 1, 1 = pull the PS/2 data line low; 0 = release it.
REQ-012 SHALL have port done, output, 1, one-cycle pulse on successful, acknowledged completion.
REQ-013 SHALL have port error, output, 1, one-cycle pulse on failed completion.
REQ-014 SHALL have port err_code, output, 2, valid with error: 2'b01 = timeout, 2'b10 = NACK; held until the next accept.

Function
REQ-015 SHALL synchronise ps2_clk_in and ps2_data_in through two flops each; a falling edge is previous synced clk = 1 and current synced clk = 0.
REQ-016 SHALL implement states IDLE, INHIBIT, RTS, SHIFT, ACK and WAIT_REL.
REQ-017 IDLE: both OEs = 0 and send_ready = 1; on accept, SHALL latch send_data, compute parity = ~^send_data (odd parity), set ps2_clk_oe = 1, clear the counter, and go to INHIBIT.
REQ-018 INHIBIT: SHALL hold ps2_clk_oe = 1 for exactly INHIBIT_CYCLES cycles, then set ps2_data_oe = 1 (start bit) and go to RTS.
REQ-019 RTS: SHALL last one cycle with both OEs = 1, then set ps2_clk_oe = 0, bit index = 0, start the timeout counter, and go to SHIFT.
REQ-020 SHIFT: on each synced falling edge SHALL drive frame bit [index]: index 0-7 = data LSB first, 8 = parity, 9 = stop (data released).
REQ-021 SHIFT: ps2_data_oe SHALL equal the inverse of the driven bit, and the output changes only on falling edges.
REQ-022 SHIFT: after the stop bit is driven (10th falling edge), the block SHALL go to ACK.
REQ-023 ACK: on the next synced falling edge, the block SHALL sample synced data; 0 = ACK, go to WAIT_REL; 1 = NACK, pulse error with err_code = 2'b10, go to IDLE.
REQ-024 WAIT_REL: when synced clk = 1 and synced data = 1, the block SHALL pulse done and go to IDLE.
REQ-025 Timeout: if the counter reaches TIMEOUT_CYCLES in SHIFT, ACK or WAIT_REL, the block SHALL release both OEs, pulse error with err_code = 2'b01, and go to IDLE; timeout takes priority over a same-cycle edge.
REQ-026 SHALL ignore send_valid while not IDLE; a new accept is possible on the cycle after returning to IDLE.
REQ-027 done and error SHALL be mutually exclusive and SHALL never both pulse for one transfer.
REQ-028 Counters SHALL saturate, never wrapping; counter width SHALL be ceil(log2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1)).

Reset
REQ-029 While reset = 1: state = IDLE, ps2_clk_oe = 0, ps2_data_oe = 0, done = 0, error = 0, err_code = 2'b00, send_ready = 0, synchronisers = 1.
REQ-030 Reset asserted mid-transfer SHALL release both lines on the next edge with no error or done pulse.
REQ-031 send_ready SHALL return to 1 on the first cycle after reset deasserts.

Verification
REQ-032 Send 8'hED with a device model that ACKs: ps2_clk_oe high for exactly 5000 cycles; frame on data = 0, 1,0,1,1,0,1,1,1, parity 1, stop 1; one done pulse; no error.
REQ-033 Send 8'h00: parity bit driven = 1; send 8'h01: parity driven = 0.
REQ-034 Device model returns data = 1 at the ACK edge: error pulse with err_code = 2'b10, both OEs = 0, send_ready = 1 on the next cycle.
REQ-035 Device model never clocks after RTS: error pulse with err_code = 2'b01 exactly TIMEOUT_CYCLES cycles after clock release; both lines released.
REQ-036 Assert reset at bit index 4: both OEs = 0 on the next cycle, no done/error pulse; a following send of 8'hF4 completes normally.
REQ-037 Hold send_valid high throughout a transfer: exactly one accept; the second transfer starts only after done.
